regfile_alu_src: RTL and testbench
==================================

Name: regfile_alu_src

Overview:
- Register file directly upstream of the 64-bit ALU. Supplies the ALU's A and B operands from two combinational read ports.
- Accepts one write per clock, normally the ALU's fout or load data.
- Holds a single-bit carry flag register that drives the ALU's carry input and is updated from the ALU carry-out.
- Together with the ALU this forms the execute-stage datapath.

Parameters:
DATA_WIDTH, 64, width of each register and of the A/B/d buses
ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH (32 registers)
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is an ordinary register

Ports:
clk    input   1           clock; all state updates on rising edge
rst    input   1           synchronous reset, active-high
sa     input   ADDR_WIDTH  read address, port A
sb     input   ADDR_WIDTH  read address, port B
da     input   ADDR_WIDTH  write address
w      input   1           write enable
d      input   DATA_WIDTH  write data
A      output  DATA_WIDTH  read data port A (to ALU A)
B      output  DATA_WIDTH  read data port B (to ALU B)
cin    input   1           carry flag next value (from ALU carry-out)
cwe    input   1           carry flag write enable
carry  output  1           current carry flag (to ALU carry)

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, rst, sampled only on the rising edge of clk.
- Storage: 2**ADDR_WIDTH x DATA_WIDTH register array plus a 1-bit carry flag register.
- Reset:
  - On a rising edge with rst=1, every register and the carry flag become 0.
  - In the same cycle, w and cwe are ignored; reset wins over a simultaneous write.
  - After that edge, A=0, B=0, carry=0 for any sa/sb.
  - Reset asserted mid-sequence discards any write presented in that cycle. No partial state survives.
- Reads:
  - Combinational, zero latency. A = reg[sa], B = reg[sb].
  - Outputs are valid in the same cycle the address changes.
  - sa == sb is legal; both ports return the same value.
- Write:
  - On a rising edge with rst=0 and w=1, reg[da] <= d.
  - The new value is visible on A/B from the cycle after the edge (write latency 1).
  - w=0 leaves all registers unchanged.
- Zero register:
  - With ZERO_REG=1, a read of address 0 returns 0 regardless of prior writes.
  - A write to da=0 is accepted on the bus and discarded.
- Carry flag:
  - On a rising edge with rst=0 and cwe=1, carry <= cin. Otherwise it holds.
  - Independent of w; a register write and a carry update may happen in the same cycle.
- Read-during-write (same address read and written in one cycle):
  - Base behaviour: the read port returns the OLD contents until the edge, then the new contents.
  - See the optional feature for the alternative.
- Address range: all 2**ADDR_WIDTH addresses are valid; there is no out-of-range case and no wrap logic.
- No X propagation: outputs are defined for all address values after the first reset.
- Sequential elements: the array and carry flag only. No FSM, no handshake; the caller sequences reads and writes.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined:
  - Write-through forwarding. When w=1, rst=0 and da==sa, A returns d combinationally in the same cycle; likewise for B when da==sb.
  - Also applies when sa==sb==da.
  - Forwarding is suppressed when ZERO_REG=1 and da=0; the port still reads 0.
  - Carry is also forwarded: when cwe=1 and rst=0, carry returns cin in the same cycle.
- Not defined:
  - No forwarding. Same-cycle reads return the pre-edge stored value (base behaviour above).

Test Plan:
- Reset: write 0xDEADBEEF_CAFEF00D to r5 and cin=1 with cwe=1, then assert rst for 1 cycle -> next cycle sa=5 gives A=0 and carry=0. Repeat with rst and w=1, da=5 in the same cycle -> r5 still 0.
- Basic write/read: w=1, da=3, d=0x0000_0000_0000_1234; next cycle sa=3, sb=3 -> A=B=0x1234. With w=0 and d changed, A stays 0x1234.
- Zero register (ZERO_REG=1): w=1, da=0, d=0xFFFF_FFFF_FFFF_FFFF -> next cycle sa=0 gives A=0. Same test with ZERO_REG=0 -> A=0xFFFF_FFFF_FFFF_FFFF.
- Read-during-write: r7 holds 0x11. Drive w=1, da=7, d=0x22, sa=7.
  - Without REGFILE_BYPASS_EN: A=0x11 before the edge, 0x22 after.
  - With REGFILE_BYPASS_EN: A=0x22 in the same cycle.
- Carry flag: cwe=1, cin=1 -> next cycle carry=1. Then cwe=0, cin=0 for 3 cycles -> carry stays 1. Simultaneous w=1 to r9 and cwe=1 -> both update on the same edge.
- Dual port sweep: write r1..r31 with value 0x100+index, then read sa=i, sb=31-i for all i -> A=0x100+i and B=0x100+(31-i), except index 0, which reads 0.

Source files
------------

// File: rtl/regfile_alu_src.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_alu_src
//  Purpose  : Register file feeding the 64-bit ALU operand buses. It has two
//             combinational read ports (A, B), one synchronous write port and
//             a 1-bit carry flag register that feeds the ALU carry input.
//  Options  : REGFILE_BYPASS_EN - when defined, a same-cycle write (and carry
//             update) is forwarded combinationally to the read outputs.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_alu_src #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] sa,
    input  logic [ADDR_WIDTH-1:0] sb,
    input  logic [ADDR_WIDTH-1:0] da,
    input  logic                  w,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B,
    input  logic                  cin,
    input  logic                  cwe,
    output logic                  carry
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [0:DEPTH-1];
    logic                  carry_q;
    logic                  carry_d;

    // Write qualifier: address 0 swallows writes when it is the hardwired zero.
    logic                  wr_en;
    logic                  zero_da;
    logic                  zero_sa;
    logic                  zero_sb;

    // Decode the hardwired-zero cases once; they only exist when ZERO_REG is set.
    always_comb begin
        zero_da = (ZERO_REG != 0) && (da == '0);
        zero_sa = (ZERO_REG != 0) && (sa == '0);
        zero_sb = (ZERO_REG != 0) && (sb == '0);
        wr_en   = w && !zero_da;
    end

    // Carry flag next value: load from the ALU carry-out when enabled.
    always_comb begin
        carry_d = cwe ? cin : carry_q;
    end

    // Storage update; reset clears everything and overrides any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
            if (wr_en) begin
                regs_q[da] <= d;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Read ports with write-through forwarding of the in-flight write/carry.
    always_comb begin
        if (zero_sa) begin
            A = '0;
        end else if (wr_en && !rst && (da == sa)) begin
            A = d;
        end else begin
            A = regs_q[sa];
        end

        if (zero_sb) begin
            B = '0;
        end else if (wr_en && !rst && (da == sb)) begin
            B = d;
        end else begin
            B = regs_q[sb];
        end

        carry = (cwe && !rst) ? cin : carry_q;
    end
`else
    // Read ports return stored contents; a same-cycle write shows up next cycle.
    always_comb begin
        A     = zero_sa ? '0 : regs_q[sa];
        B     = zero_sb ? '0 : regs_q[sb];
        carry = carry_q;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_alu_src.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_alu_src
//  Purpose  : Self-checking bench for regfile_alu_src. Two instances (hardwired
//             zero register on / off) share stimulus; a behavioural model is
//             compared against both on every falling clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_alu_src;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NR = 32;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] sa, sb, da;
    logic          w;
    logic [DW-1:0] d;
    logic          cin, cwe;

    logic [DW-1:0] a_z1, b_z1, a_z0, b_z0;
    logic          c_z1, c_z0;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: plain arrays of register contents and a carry bit.
    logic [DW-1:0] m_z1 [NR];
    logic [DW-1:0] m_z0 [NR];
    logic          m_c;
    bit            model_valid = 1'b0;

    always #5 clk = ~clk;

    regfile_alu_src #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) u_z1 (
        .clk(clk), .rst(rst), .sa(sa), .sb(sb), .da(da), .w(w), .d(d),
        .A(a_z1), .B(b_z1), .cin(cin), .cwe(cwe), .carry(c_z1)
    );

    regfile_alu_src #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0)) u_z0 (
        .clk(clk), .rst(rst), .sa(sa), .sb(sb), .da(da), .w(w), .d(d),
        .A(a_z0), .B(b_z0), .cin(cin), .cwe(cwe), .carry(c_z0)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Expected read value for a port of the instance with (z=1) or without (z=0)
    // the hardwired zero register.
    function automatic logic [DW-1:0] exp_rd(input bit z, input logic [AW-1:0] addr);
        if (z && addr == 0) return '0;
        if (BYP && w && !rst && da == addr) return d;
        return z ? m_z1[addr] : m_z0[addr];
    endfunction

    function automatic logic exp_carry();
        if (BYP && cwe && !rst) return cin;
        return m_c;
    endfunction

    // Model state update on the clock edge using the inputs held across it.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                m_z1[i] = '0;
                m_z0[i] = '0;
            end
            m_c = 1'b0;
            model_valid = 1'b1;
        end else begin
            if (w) begin
                m_z1[da] = d;
                m_z0[da] = d;
            end
            if (cwe) m_c = cin;
        end
    end

    // Continuous comparison mid-cycle, once the model has been reset.
    always @(negedge clk) begin
        if (model_valid) begin
            check("A_zero1", a_z1, exp_rd(1'b1, sa));
            check("B_zero1", b_z1, exp_rd(1'b1, sb));
            check("A_zero0", a_z0, exp_rd(1'b0, sa));
            check("B_zero0", b_z0, exp_rd(1'b0, sb));
            check("carry_zero1", {63'd0, c_z1}, {63'd0, exp_carry()});
            check("carry_zero0", {63'd0, c_z0}, {63'd0, exp_carry()});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w   = 1'b0;
        cwe = 1'b0;
        cin = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sa = '0; sb = '0; da = '0; w = 1'b0; d = '0; cin = 1'b0; cwe = 1'b0;
        cyc();
        idle();

        // Reset clears a written register and the carry flag.
        w = 1'b1; da = 5'd5; d = 64'hDEADBEEF_CAFEF00D; cwe = 1'b1; cin = 1'b1;
        cyc();
        idle(); sa = 5'd5; #1;
        check("pre_reset_r5", a_z1, 64'hDEADBEEF_CAFEF00D);
        rst = 1'b1;
        cyc();
        idle(); sa = 5'd5; #1;
        check("reset_r5", a_z1, 64'd0);
        check("reset_carry", {63'd0, c_z1}, 64'd0);

        // Reset wins over a simultaneous write and carry update.
        rst = 1'b1; w = 1'b1; da = 5'd5; d = 64'h1111_2222_3333_4444; cwe = 1'b1; cin = 1'b1;
        cyc();
        idle(); sa = 5'd5; #1;
        check("reset_wins_r5", a_z0, 64'd0);
        check("reset_wins_carry", {63'd0, c_z0}, 64'd0);

        // Basic write then dual read; w=0 holds the value.
        w = 1'b1; da = 5'd3; d = 64'h1234;
        cyc();
        w = 1'b0; d = 64'hFFFF_0000_FFFF_0000; sa = 5'd3; sb = 5'd3; #1;
        check("basic_A", a_z1, 64'h1234);
        check("basic_B", b_z1, 64'h1234);
        check("model_r3", m_z1[3], 64'h1234);
        cyc();
        check("hold_A", a_z1, 64'h1234);

        // Hardwired zero register versus ordinary register 0.
        w = 1'b1; da = 5'd0; d = '1;
        cyc();
        w = 1'b0; sa = 5'd0; #1;
        check("zero_reg_on", a_z1, 64'd0);
        check("zero_reg_off", a_z0, 64'hFFFF_FFFF_FFFF_FFFF);

        // Read-during-write to r7.
        w = 1'b1; da = 5'd7; d = 64'h11;
        cyc();
        w = 1'b1; da = 5'd7; d = 64'h22; sa = 5'd7; #1;
        check("rdw_same_cycle", a_z1, BYP ? 64'h22 : 64'h11);
        cyc();
        w = 1'b0; #1;
        check("rdw_after_edge", a_z1, 64'h22);

        // Carry set, then held for three cycles with cwe=0, cin=0.
        cwe = 1'b1; cin = 1'b1;
        cyc();
        cwe = 1'b0; cin = 1'b0; #1;
        check("carry_set", {63'd0, c_z1}, 64'd1);
        repeat (3) cyc();
        check("carry_hold", {63'd0, c_z1}, 64'd1);

        // Register write and carry update on the same edge.
        w = 1'b1; da = 5'd9; d = 64'h99; cwe = 1'b1; cin = 1'b0;
        cyc();
        idle(); sa = 5'd9; #1;
        check("simul_r9", a_z1, 64'h99);
        check("simul_carry", {63'd0, c_z1}, 64'd0);

        // Dual-port sweep across all addresses.
        for (int i = 1; i < NR; i++) begin
            w = 1'b1; da = AW'(i); d = 64'(32'h100 + i);
            cyc();
        end
        w = 1'b0;
        for (int i = 0; i < NR; i++) begin
            sa = AW'(i); sb = AW'(31 - i); #1;
            check("sweep_A", a_z1, (i == 0) ? 64'd0 : 64'(32'h100 + i));
            check("sweep_B", b_z1, (i == 31) ? 64'd0 : 64'(32'h100 + 31 - i));
        end
        cyc();

        // Randomized traffic, checked every cycle against the model.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            w   = $urandom_range(0, 1);
            cwe = $urandom_range(0, 2) == 0;
            cin = $urandom_range(0, 1);
            da  = AW'($urandom_range(0, NR - 1));
            sa  = ($urandom_range(0, 3) == 0) ? da : AW'($urandom_range(0, NR - 1));
            sb  = ($urandom_range(0, 3) == 0) ? sa : AW'($urandom_range(0, NR - 1));
            d   = {$urandom, $urandom};
            cyc();
        end
        idle();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
